// File: rtl/watch_pkg.sv
// Shared types and constants for the watch mode controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package watch_pkg;

  typedef enum logic [2:0] {
    MODE_TIME   = 3'd0,
    MODE_SWATCH = 3'd1,
    MODE_ALSET  = 3'd2,
    MODE_TSET   = 3'd3,
    MODE_CDOWN  = 3'd4
  } mode_e;

  // One-cycle output strobes, kept together so they clear as a group.
  typedef struct packed {
    logic ack;
    logic dec;
    logic inc;
    logic cd_ss;
    logic sw_rst;
    logic sw_ss;
  } pulse_t;

  localparam int BTN_MODE   = 0;
  localparam int BTN_ACTION = 1;
  localparam int BTN_INC    = 2;
  localparam int BTN_DEC    = 3;
  localparam int NUM_BTN    = 4;

  localparam int DEF_TIMEOUT_TICKS = 300;
  localparam int DEF_RPT_DELAY     = 5;
  localparam int DEF_RPT_PERIOD    = 2;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_TIME:   return MODE_SWATCH;
      MODE_SWATCH: return MODE_ALSET;
      MODE_ALSET:  return MODE_TSET;
      MODE_TSET:   return MODE_CDOWN;
      default:     return MODE_TIME;
    endcase
  endfunction

  // Modes with an hours/minutes field and an inactivity timeout.
  function automatic logic is_set_mode(input mode_e m);
    return (m == MODE_ALSET) || (m == MODE_TSET);
  endfunction

  // Modes where INC/DEC adjust a value (and therefore auto-repeat).
  function automatic logic is_adj_mode(input mode_e m);
    return is_set_mode(m) || (m == MODE_CDOWN);
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_if.sv
// Button/tick inputs and mode/strobe outputs of the watch mode controller.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are level or single-cycle strobes.
interface watch_mode_ctrl_if;
  logic       tick_10hz;
  logic [3:0] buttons;
  logic       alarm_ring;
  logic       cd_expired;
  logic [2:0] mode;
  logic       field_hr;
  logic       sw_ss_p;
  logic       sw_rst_p;
  logic       cd_ss_p;
  logic       inc_p;
  logic       dec_p;
  logic       buzzer;
  logic       ack_p;

  modport slave (
    input  tick_10hz, buttons, alarm_ring, cd_expired,
    output mode, field_hr, sw_ss_p, sw_rst_p, cd_ss_p, inc_p, dec_p, buzzer, ack_p
  );

  modport master (
    output tick_10hz, buttons, alarm_ring, cd_expired,
    input  mode, field_hr, sw_ss_p, sw_rst_p, cd_ss_p, inc_p, dec_p, buzzer, ack_p
  );
endinterface

// File: rtl/btn_repeat.sv
// Edge detect plus hold/auto-repeat for one debounced button.
// Latency: press_o/rpt_o are combinational strobes meant to feed the caller's registers.
// Backpressure: none; kill_i disarms the repeat (release, mode change, consumed or dropped press).
module btn_repeat
  import watch_pkg::*;
#(
  parameter bit RPT_EN     = 1'b0,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic uclock,
  input  logic nreset,
  input  logic btn_i,
  input  logic tick_i,
  input  logic kill_i,
  output logic press_o,
  output logic rpt_o
);

  // Assumes RPT_PERIOD <= RPT_DELAY so the reload value is non-negative.
  localparam int CW = (RPT_DELAY < 2) ? 1 : $clog2(RPT_DELAY + 1);

  logic          btn_q;
  logic          armed_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          held;

  assign press_o = btn_i & ~btn_q;
  assign held    = RPT_EN & armed_q & btn_i & btn_q;
  assign cnt_d   = cnt_q + CW'(1);
  assign rpt_o   = held & tick_i & (cnt_d == CW'(RPT_DELAY));

  // Edge register resets high so a button held through reset is not a press;
  // after the first repeat the counter reloads so later repeats come every RPT_PERIOD ticks.
  always_ff @(posedge uclock or negedge nreset) begin
    if (!nreset) begin
      btn_q   <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      btn_q <= btn_i;
      if (kill_i || !btn_i || !RPT_EN) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else if (press_o) begin
        armed_q <= 1'b1;
        cnt_q   <= '0;
      end else if (held && tick_i) begin
        cnt_q <= rpt_o ? CW'(RPT_DELAY - RPT_PERIOD) : cnt_d;
      end
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch UI mode FSM: routes button presses to stopwatch/countdown/set strobes, drives buzzer/ack.
// Latency: one uclock from sampled button edge or tick to registered output.
// Backpressure: none; while the buzzer sounds every press becomes ack_p only.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int RPT_DELAY     = DEF_RPT_DELAY,
  parameter int RPT_PERIOD    = DEF_RPT_PERIOD
) (
  input  logic               uclock,
  input  logic               nreset,
  watch_mode_ctrl_if.slave   bus
);

  localparam int IW = $clog2(TIMEOUT_TICKS + 1);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rpt;
  logic [NUM_BTN-1:0] kill;

  mode_e   mode_q, mode_d;
  logic    field_hr_q, field_hr_d;
  logic    buzzer_q, buzzer_d;
  pulse_t  pls_q, pls_d;
  logic [IW-1:0] idle_q, idle_d;
  logic    timeout;
  logic    mode_chg;
  logic    base_kill;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_repeat #(
      .RPT_EN    ((i == BTN_INC) || (i == BTN_DEC)),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_btn (
      .uclock (uclock),
      .nreset (nreset),
      .btn_i  (bus.buttons[i]),
      .tick_i (bus.tick_10hz),
      .kill_i (kill[i]),
      .press_o(press[i]),
      .rpt_o  (rpt[i])
    );
  end

  // Next-state: buzzer consume, prioritised press routing, repeats, timeout, idle count, repeat kills.
  always_comb begin
    mode_d     = mode_q;
    field_hr_d = field_hr_q;
    buzzer_d   = bus.alarm_ring | bus.cd_expired;
    pls_d      = '0;
    idle_d     = idle_q;
    timeout    = is_set_mode(mode_q) && (idle_q == IW'(TIMEOUT_TICKS));

    if (buzzer_q) begin
      if (|press) pls_d.ack = 1'b1;
    end else if (press[BTN_MODE]) begin
      mode_d = next_mode(mode_q);
    end else if (press[BTN_ACTION]) begin
      case (mode_q)
        MODE_SWATCH:           pls_d.sw_ss = 1'b1;
        MODE_CDOWN:            pls_d.cd_ss = 1'b1;
        MODE_ALSET, MODE_TSET: field_hr_d  = ~field_hr_q;
        default:               ;
      endcase
    end else if (press[BTN_INC]) begin
      if (is_adj_mode(mode_q)) pls_d.inc = 1'b1;
    end else if (press[BTN_DEC]) begin
      if (mode_q == MODE_SWATCH)     pls_d.sw_rst = 1'b1;
      else if (is_adj_mode(mode_q))  pls_d.dec    = 1'b1;
    end else if (rpt[BTN_INC] && is_adj_mode(mode_q)) begin
      pls_d.inc = 1'b1;
    end else if (rpt[BTN_DEC] && is_adj_mode(mode_q)) begin
      pls_d.dec = 1'b1;
    end

    if (timeout) mode_d = MODE_TIME;

    mode_chg = (mode_d != mode_q);
    if (mode_chg) field_hr_d = 1'b0;

    // Repeat strobes count as activity so a held INC/DEC never times out mid-adjust.
    if (!is_set_mode(mode_q) || (|press) || (|rpt)) idle_d = '0;
    else if (bus.tick_10hz && !timeout)             idle_d = idle_q + IW'(1);

    // A repeat only survives if its press was actually acted on in an adjust mode.
    base_kill          = buzzer_q | ~is_adj_mode(mode_q) | mode_chg;
    kill               = {NUM_BTN{1'b1}};
    kill[BTN_INC]      = base_kill | (press[BTN_INC] & (press[BTN_MODE] | press[BTN_ACTION]));
    kill[BTN_DEC]      = base_kill | (press[BTN_DEC] &
                         (press[BTN_MODE] | press[BTN_ACTION] | press[BTN_INC]));
  end

  // State and output registers.
  always_ff @(posedge uclock or negedge nreset) begin
    if (!nreset) begin
      mode_q     <= MODE_TIME;
      field_hr_q <= 1'b0;
      buzzer_q   <= 1'b0;
      pls_q      <= '0;
      idle_q     <= '0;
    end else begin
      mode_q     <= mode_d;
      field_hr_q <= field_hr_d;
      buzzer_q   <= buzzer_d;
      pls_q      <= pls_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.mode     = mode_q;
  assign bus.field_hr = field_hr_q;
  assign bus.buzzer   = buzzer_q;
  assign bus.sw_ss_p  = pls_q.sw_ss;
  assign bus.sw_rst_p = pls_q.sw_rst;
  assign bus.cd_ss_p  = pls_q.cd_ss;
  assign bus.inc_p    = pls_q.inc;
  assign bus.dec_p    = pls_q.dec;
  assign bus.ack_p    = pls_q.ack;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: directed stimulus queues expected events,
// a negedge monitor pops and compares every observable output event.
// Timeout shortened to 10 ticks; repeat delay/period at 5/2.
module tb_watch_mode_ctrl;
  import watch_pkg::*;

  logic uclock = 1'b0;
  logic nreset = 1'b0;
  always #5 uclock = ~uclock;

  watch_mode_ctrl_if bus();

  watch_mode_ctrl #(
    .TIMEOUT_TICKS(10),
    .RPT_DELAY    (5),
    .RPT_PERIOD   (2)
  ) dut (
    .uclock(uclock),
    .nreset(nreset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] mode;
    logic       field;
    logic       buzz;
    logic [5:0] pls;   // {ack, dec, inc, cd_ss, sw_rst, sw_ss}
  } ev_t;

  localparam logic [5:0] P_NONE  = 6'b000000;
  localparam logic [5:0] P_SWSS  = 6'b000001;
  localparam logic [5:0] P_SWRST = 6'b000010;
  localparam logic [5:0] P_CDSS  = 6'b000100;
  localparam logic [5:0] P_INC   = 6'b001000;
  localparam logic [5:0] P_DEC   = 6'b010000;
  localparam logic [5:0] P_ACK   = 6'b100000;

  ev_t exp_q[$];
  ev_t cur, prev, want;
  int  checks   = 0;
  int  failures = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge uclock);
    #1;
  endtask

  task automatic expect_ev(input logic [2:0] m, input logic f, input logic b, input logic [5:0] p);
    ev_t e;
    e.mode  = m;
    e.field = f;
    e.buzz  = b;
    e.pls   = p;
    exp_q.push_back(e);
  endtask

  task automatic push_btn(input int idx);
    bus.buttons[idx] = 1'b1;
    cyc(1);
    bus.buttons[idx] = 1'b0;
    cyc(1);
  endtask

  task automatic tick();
    bus.tick_10hz = 1'b1;
    cyc(1);
    bus.tick_10hz = 1'b0;
    cyc(2);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: any strobe or any change of mode/field/buzzer is one event to match.
  always @(negedge uclock) begin
    if (!nreset) begin
      prev = '0;
    end else begin
      cur = {bus.mode, bus.field_hr, bus.buzzer, bus.ack_p, bus.dec_p,
             bus.inc_p, bus.cd_ss_p, bus.sw_rst_p, bus.sw_ss_p};
      if ((cur.pls != 6'b0) || ({cur.mode, cur.field, cur.buzz} != {prev.mode, prev.field, prev.buzz})) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got mode=%0d field=%0b buzzer=%0b pulses=%b expected no event",
                   cur.mode, cur.field, cur.buzz, cur.pls);
        end else begin
          want = exp_q.pop_front();
          if (cur !== want) begin
            failures++;
            $display("FAIL event got mode=%0d field=%0b buzzer=%0b pulses=%b expected mode=%0d field=%0b buzzer=%0b pulses=%b",
                     cur.mode, cur.field, cur.buzz, cur.pls, want.mode, want.field, want.buzz, want.pls);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.buttons    = 4'b0;
    bus.tick_10hz  = 1'b0;
    bus.alarm_ring = 1'b0;
    bus.cd_expired = 1'b0;
    nreset         = 1'b0;
    cyc(3);
    chk("reset_mode",   8'(bus.mode),     8'd0);
    chk("reset_field",  8'(bus.field_hr), 8'd0);
    chk("reset_buzzer", 8'(bus.buzzer),   8'd0);
    chk("reset_pulses", 8'({bus.ack_p, bus.dec_p, bus.inc_p, bus.cd_ss_p, bus.sw_rst_p, bus.sw_ss_p}), 8'd0);
    nreset = 1'b1;
    cyc(2);

    // MODE cycles through all five modes back to TIME.
    for (int i = 1; i <= 5; i++) begin
      expect_ev(3'(i % 5), 1'b0, 1'b0, P_NONE);
      push_btn(BTN_MODE);
    end

    // TIME ignores ACTION/INC/DEC.
    push_btn(BTN_ACTION);
    push_btn(BTN_INC);
    push_btn(BTN_DEC);

    // Stopwatch routing; INC ignored.
    expect_ev(3'd1, 1'b0, 1'b0, P_NONE);  push_btn(BTN_MODE);
    expect_ev(3'd1, 1'b0, 1'b0, P_SWSS);  push_btn(BTN_ACTION);
    expect_ev(3'd1, 1'b0, 1'b0, P_SWRST); push_btn(BTN_DEC);
    push_btn(BTN_INC);

    // TSET: toggle field, then hold INC for 11 ticks.
    expect_ev(3'd2, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    expect_ev(3'd3, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    expect_ev(3'd3, 1'b1, 1'b0, P_NONE); push_btn(BTN_ACTION);
    expect_ev(3'd3, 1'b1, 1'b0, P_INC);
    bus.buttons[BTN_INC] = 1'b1;
    cyc(2);
    for (int k = 1; k <= 11; k++) begin
      if (k >= 5 && (k % 2) == 1) expect_ev(3'd3, 1'b1, 1'b0, P_INC);
      tick();
    end
    bus.buttons[BTN_INC] = 1'b0;
    cyc(2);

    // CDOWN entry clears field; INC/DEC/ACTION routing.
    expect_ev(3'd4, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    expect_ev(3'd4, 1'b0, 1'b0, P_INC);  push_btn(BTN_INC);
    expect_ev(3'd4, 1'b0, 1'b0, P_DEC);  push_btn(BTN_DEC);
    expect_ev(3'd4, 1'b0, 1'b0, P_CDSS); push_btn(BTN_ACTION);
    expect_ev(3'd0, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    expect_ev(3'd1, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    expect_ev(3'd2, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);

    // ALSET timeout: press at tick 9 restarts the count, then 10 idle ticks exit.
    repeat (9) tick();
    expect_ev(3'd2, 1'b0, 1'b0, P_DEC); push_btn(BTN_DEC);
    repeat (9) tick();
    chk("no_timeout_at_9", 8'(bus.mode), 8'd2);
    expect_ev(3'd0, 1'b0, 1'b0, P_NONE);
    tick();
    cyc(2);
    chk("timeout_to_time", 8'(bus.mode), 8'd0);

    // Alarm: buzzer on, press consumed as ack, buzzer off one cycle after release.
    expect_ev(3'd0, 1'b0, 1'b1, P_NONE);
    bus.alarm_ring = 1'b1;
    cyc(2);
    expect_ev(3'd0, 1'b0, 1'b1, P_ACK); push_btn(BTN_MODE);
    chk("ack_mode_kept", 8'(bus.mode), 8'd0);
    expect_ev(3'd0, 1'b0, 1'b0, P_NONE);
    bus.alarm_ring = 1'b0;
    cyc(1);
    chk("buzzer_off_next", 8'(bus.buzzer), 8'd0);
    cyc(1);

    // Press coinciding with buzzer rise is routed; later press is consumed.
    expect_ev(3'd1, 1'b0, 1'b1, P_NONE);
    bus.cd_expired        = 1'b1;
    bus.buttons[BTN_MODE] = 1'b1;
    cyc(1);
    bus.buttons[BTN_MODE] = 1'b0;
    cyc(1);
    expect_ev(3'd1, 1'b0, 1'b1, P_ACK); push_btn(BTN_DEC);
    expect_ev(3'd1, 1'b0, 1'b0, P_NONE);
    bus.cd_expired = 1'b0;
    cyc(2);

    // MODE and INC together in ALSET: MODE wins, INC neither pulses nor repeats.
    expect_ev(3'd2, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    expect_ev(3'd3, 1'b0, 1'b0, P_NONE);
    bus.buttons[BTN_MODE] = 1'b1;
    bus.buttons[BTN_INC]  = 1'b1;
    cyc(1);
    bus.buttons[BTN_MODE] = 1'b0;
    repeat (6) tick();
    bus.buttons[BTN_INC] = 1'b0;
    cyc(2);

    // Reset mid-hold: no trailing repeat, held buttons are not presses afterwards.
    expect_ev(3'd3, 1'b0, 1'b0, P_INC);
    bus.buttons[BTN_INC] = 1'b1;
    cyc(2);
    repeat (4) tick();
    bus.buttons[BTN_MODE] = 1'b1;
    nreset = 1'b0;
    cyc(1);
    chk("rst_mode", 8'(bus.mode), 8'd0);
    chk("rst_inc",  8'(bus.inc_p), 8'd0);
    cyc(1);
    nreset = 1'b1;
    cyc(1);
    repeat (8) tick();
    chk("held_through_reset", 8'(bus.mode), 8'd0);
    bus.buttons = 4'b0;
    cyc(2);
    expect_ev(3'd1, 1'b0, 1'b0, P_NONE); push_btn(BTN_MODE);
    cyc(5);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got=%0d pending expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 300, idle tick_10hz pulses before set modes auto-exit (30 s).
REQ-002 Parameter RPT_DELAY, default 5, ticks INC/DEC must be held before auto-repeat starts.
REQ-003 Parameter RPT_PERIOD, default 2, ticks between auto-repeat pulses.
REQ-004 uclock  in  1  sole clock; all state on its rising edge.
REQ-005 nreset  in  1  asynchronous, active-low reset.
REQ-006 tick_10hz  in  1  one-uclock enable pulse every 1/10 s.
REQ-007 buttons  in  4  debounced levels; [0]=MODE, [1]=ACTION, [2]=INC, [3]=DEC.
REQ-008 alarm_ring  in  1  alarm match active (level).
REQ-009 cd_expired  in  1  countdown reached zero (level).
REQ-010 mode  out  3  current mode encoding.
REQ-011 field_hr  out  1  set-mode field select: 1=hours, 0=minutes.
REQ-012 sw_ss_p, sw_rst_p  out  1 each  stopwatch start/stop and reset pulses.
REQ-013 cd_ss_p  out  1  countdown start/pause pulse.
REQ-014 inc_p, dec_p  out  1 each  increment/decrement pulses to the field owned by the current mode.
REQ-015 buzzer  out  1  shared buzzer drive.
REQ-016 ack_p  out  1  silence pulse to alarm and countdown logic.

Function
REQ-017 Press = rising edge of a buttons bit; every output pulse SHALL be exactly one uclock wide, registered, 1-cycle latency from the sampled edge.
REQ-018 Modes: TIME=0, SWATCH=1, ALSET=2, TSET=3, CDOWN=4; MODE press cycles TIME->SWATCH->ALSET->TSET->CDOWN->TIME.
REQ-019 ACTION routing: SWATCH->sw_ss_p; CDOWN->cd_ss_p; ALSET/TSET->toggle field_hr; TIME->ignored.
REQ-020 INC routing: ALSET/TSET/CDOWN->inc_p; otherwise ignored.
REQ-021 DEC routing: SWATCH->sw_rst_p; ALSET/TSET/CDOWN->dec_p; TIME->ignored.
REQ-022 Every mode entry SHALL clear field_hr to 0.
REQ-023 Same-cycle multiple presses: only the highest-priority one is acted on (MODE > ACTION > INC > DEC); others are dropped.
REQ-024 Auto-repeat: in ALSET/TSET/CDOWN, INC or DEC held RPT_DELAY ticks SHALL emit one extra pulse, then one every RPT_PERIOD ticks until release; release or mode change cancels the repeat.
REQ-025 Timeout: in ALSET/TSET, an idle counter of tick_10hz SHALL clear on any press; reaching TIMEOUT_TICKS forces mode=TIME on the next cycle.
REQ-026 buzzer = registered (alarm_ring OR cd_expired); alarm has no priority over countdown because both share one output.
REQ-027 While buzzer=1, any press SHALL produce ack_p and is consumed: no routing, no mode change, no repeat.
REQ-028 A press coinciding with buzzer rising is routed normally; the consume rule applies from the cycle buzzer reads 1.
REQ-029 Idle counter saturates and does not wrap; repeat counters do not advance without tick_10hz.

Reset
REQ-030 On nreset low: mode=TIME, field_hr=0, buzzer=0, all pulses=0, idle and repeat counters=0.
REQ-031 Edge-detect registers reset to 1, so a button held through reset release does not register a press.
REQ-032 Reset asserted mid-repeat or mid-timeout SHALL abort both immediately, with no trailing pulse.

Structure
REQ-033 Shared package watch_pkg holds the mode encodings, button index constants and default TIMEOUT/RPT values.
REQ-034 One sub-module, btn_repeat, SHALL perform edge detection plus hold/auto-repeat for one button; instantiate it four times, with repeat enabled only on INC/DEC.
REQ-035 Implement the mode FSM as a single registered next-state process; no combinational path from buttons to outputs.

Verification
REQ-036 Reset, then pulse MODE 5 times -> mode 0,1,2,3,4,0; exactly one mode step per press.
REQ-037 mode=SWATCH, press ACTION then DEC -> one sw_ss_p, then one sw_rst_p; inc_p/dec_p stay 0.
REQ-038 mode=TSET, hold INC for 11 ticks -> inc_p on press, then at ticks 5, 7, 9, 11 (5 pulses total).
REQ-039 mode=ALSET with TIMEOUT_TICKS=10, no presses for 10 ticks -> mode=0; one press at tick 9 restarts the count.
REQ-040 alarm_ring=1, press MODE -> buzzer=1, one ack_p, mode unchanged; alarm_ring=0 -> buzzer=0 next cycle.
REQ-041 MODE and INC rise in the same cycle in ALSET -> mode=3, no inc_p; nreset pulsed while INC held -> no press after release of reset.
